sar_search: RTL and testbench
=============================

Name: sar_search

Overview:
- Successive-approximation search engine: the initiator side of the 4-bit magnitude comparator interface.
- Drives a trial value onto the comparator's b operand. The comparator's a operand holds an unknown target.
- Reads back equal/greater/lesser each cycle and converges on the target MSB-first, one bit per cycle.
- Sits beside the comparator in the lab datapath; also used as a self-checking stimulus source for comparator builds.

Parameters:
- WIDTH, 4, operand width; must match comparator width (>=1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  begin search; sampled only in IDLE.
- guess  output  WIDTH  trial value to comparator b operand; registered.
- cmp_equal  input  1  comparator equal (target == guess).
- cmp_greater  input  1  comparator greater (target > guess).
- cmp_lesser  input  1  comparator lesser (target < guess).
- busy  output  1  high in PROBE.
- done  output  1  one-cycle pulse in DONE.
- result  output  WIDTH  converged target value; held until next accepted start.
- found  output  1  an equal compare was seen on some probe; held like result.
- err  output  1  invalid comparator flags seen; held like result.

Behaviour:
- One clock; reset asynchronous and active-low (rst_n), synchronous deassertion handled upstream.
- Reset values:
  - state=IDLE, guess=0, busy=0, done=0, result=0, found=0, err=0.
  - Internal bit index idx=WIDTH-1; working value trial=0.
- Comparator path is combinational. Cmp inputs are sampled in the same cycle guess is presented: one probe per clock.
- States: IDLE, PROBE, DONE.
- IDLE:
  - start=1 -> PROBE; guess<=1<<(WIDTH-1); idx<=WIDTH-1; clear result/found/err.
  - start=0 -> stay; guess holds last value.
- PROBE, each cycle: the flag combination must be exactly one-hot.
  - Not one-hot (none or several set) -> err<=1, result<=guess, found<=0, go DONE.
  - cmp_equal -> result<=guess, found<=1, go DONE (early termination).
  - cmp_greater -> keep bit idx of guess.
  - cmp_lesser -> clear bit idx of guess.
  - After keep/clear:
    - idx==0 -> result<=updated value, found<=0, go DONE.
    - else idx<=idx-1; guess<=updated | (1<<(idx-1)).
- DONE: done=1 for exactly this cycle, busy=0, -> IDLE. start is ignored in DONE and PROBE (no queuing).
- Latency: start sampled at edge N. First probe presented from N+1. done asserts at most WIDTH+1 cycles after N, minimum 2 (MSB-equal case).
- Non-equal exit always gives result == target (floor property of SAR). Target 0 gives result 0, found 0.
- guess is never X and never changes mid-cycle; only registered updates.
- rst_n low mid-search: immediate return to reset values; no done pulse; the search is lost.
- start held high continuously: a new search begins in the IDLE cycle that follows each DONE, giving back-to-back searches with one idle cycle between them.

Test Plan:
- WIDTH=4, target 11, comparator model a=target, b=guess, start pulse -> guess sequence 8,12,10,11. Equal on the 4th probe -> done, result=11, found=1, err=0, done 5 cycles after start.
- Target 8 -> single probe 8 equal -> done 2 cycles after start, result=8, found=1. Busy high for exactly 1 cycle.
- Target 0 -> probes 8,4,2,1, all lesser -> result=0, found=0, done 5 cycles after start. Target 15 -> probes 8,12,14,15 -> result=15, found=1.
- Force cmp flags all 0 on the 2nd probe (target 11) -> err=1, result=12, found=0, done on that probe's cycle+1. Repeat with greater+lesser both high -> same err outcome.
- Start pulsed again while busy (target 5) -> ignored; search completes with result=5 and a single done pulse. rst_n low on the 3rd probe -> all outputs 0 asynchronously, no done; a later start runs cleanly.
- Exhaustive sweep: targets 0..15 with start held high -> every result equals target, found=0 only for target 0, no err. A new search begins one idle cycle after each done.

Source files
------------

// File: rtl/sar_search.sv
// -----------------------------------------------------------------------------
// sar_search
//
// Successive-approximation search engine. It is the initiator side of a
// WIDTH-bit magnitude comparator: it drives a trial value onto the
// comparator's b operand, reads back equal/greater/lesser in the same cycle,
// and converges on the unknown a operand MSB-first, one bit per clock.
//
// Ports
//   clk          in   rising-edge system clock
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a search; only looked at while idle
//   guess        out  [WIDTH] registered trial value to comparator b
//   cmp_equal    in   comparator: target == guess
//   cmp_greater  in   comparator: target >  guess
//   cmp_lesser   in   comparator: target <  guess
//   busy         out  high while probing
//   done         out  one-cycle pulse when a search finishes
//   result       out  [WIDTH] converged value, held until the next start
//   found        out  an equal compare ended the search, held like result
//   err          out  an invalid flag combination ended it, held like result
// -----------------------------------------------------------------------------
module sar_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  input  logic             cmp_equal,
  input  logic             cmp_greater,
  input  logic             cmp_lesser,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  // Bit index needs at least one bit even for WIDTH == 1.
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_MASK = ONE << (WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] guess_q,  guess_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             found_q,  found_d;
  logic             err_q,    err_d;

  logic             flags_onehot;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] updated;

  // A healthy comparator asserts exactly one of its three flags.
  always_comb begin
    flags_onehot = 1'b0;
    case ({cmp_equal, cmp_greater, cmp_lesser})
      3'b100, 3'b010, 3'b001: flags_onehot = 1'b1;
      default:                flags_onehot = 1'b0;
    endcase
  end

  // Keep the probed bit when the target is above the guess, drop it when below.
  assign bit_mask = ONE << idx_q;
  assign updated  = cmp_greater ? guess_q : (guess_q & ~bit_mask);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    guess_d  = guess_q;
    idx_d    = idx_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = PROBE;
          guess_d  = MSB_MASK;
          idx_d    = IDX_MSB;
          result_d = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
        end
      end

      PROBE: begin
        if (!flags_onehot) begin
          // Comparator is broken or disconnected: report what was on the bus.
          state_d  = DONE;
          err_d    = 1'b1;
          result_d = guess_q;
          found_d  = 1'b0;
        end else if (cmp_equal) begin
          state_d  = DONE;
          result_d = guess_q;
          found_d  = 1'b1;
        end else if (idx_q == '0) begin
          // Last bit resolved without an exact hit; floor property makes the
          // updated value the target.
          state_d  = DONE;
          result_d = updated;
          found_d  = 1'b0;
        end else begin
          idx_d   = idx_q - IDX_ONE;
          guess_d = updated | (ONE << (idx_q - IDX_ONE));
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      guess_q  <= '0;
      idx_q    <= IDX_MSB;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge, independent of statement order.
      state_q  <= state_d;
      guess_q  <= guess_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  // Status outputs decode straight from the state register, so they are
  // glitch-free and change only on a clock edge or reset.
  assign busy   = (state_q == PROBE);
  assign done   = (state_q == DONE);
  assign guess  = guess_q;
  assign result = result_q;
  assign found  = found_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// -----------------------------------------------------------------------------
// tb_sar_search
//
// Directed bench for sar_search (WIDTH=4). A behavioural comparator holds the
// target on operand a and compares it against guess; it can be told to corrupt
// its flags on a chosen guess value to exercise the error path.
// -----------------------------------------------------------------------------
module tb_sar_search;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] guess;
  logic             cmp_equal;
  logic             cmp_greater;
  logic             cmp_lesser;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             err;

  // Comparator model controls.
  logic [WIDTH-1:0] target;
  int               inj_mode;   // 0 none, 1 all flags low, 2 greater+lesser
  logic [WIDTH-1:0] inj_guess;

  int n_checks;
  int n_errors;

  // Observations gathered by run_search.
  logic [15:0] probes_packed;
  int          n_probes;
  int          busy_cycles;
  int          latency;
  bit          done_seen;

  sar_search #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .guess       (guess),
    .cmp_equal   (cmp_equal),
    .cmp_greater (cmp_greater),
    .cmp_lesser  (cmp_lesser),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .found       (found),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural magnitude comparator: a = target, b = guess.
  always_comb begin
    cmp_equal   = (target == guess);
    cmp_greater = (target >  guess);
    cmp_lesser  = (target <  guess);
    if (inj_mode != 0 && busy && guess == inj_guess) begin
      cmp_equal   = 1'b0;
      cmp_greater = (inj_mode == 2);
      cmp_lesser  = (inj_mode == 2);
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start for one accepted edge, then log each probe until done.
  // latency counts clock edges from the start-sampling edge to the edge that
  // would capture done.
  task automatic run_search(input logic [WIDTH-1:0] tgt);
    target        = tgt;
    probes_packed = '0;
    n_probes      = 0;
    busy_cycles   = 0;
    done_seen     = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    latency = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) begin
        probes_packed = {probes_packed[11:0], guess};
        n_probes++;
        busy_cycles++;
      end
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      @(posedge clk);
      latency++;
    end
    check("done_seen", 32'(done_seen), 32'd1);
  endtask

  // Wait for done with a bounded budget, sampling on the falling edge.
  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int done_cnt;
    int n_busy;
    bit seen;

    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    target    = '0;
    inj_mode  = 0;
    inj_guess = '0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_guess",  32'(guess),  32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_found",  32'(found),  32'd0);
    check("rst_err",    32'(err),    32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // ---- target 11: 8,12,10,11 with equal on the 4th probe ----
    run_search(4'd11);
    check("t11_probes", 32'(probes_packed), 32'h8CAB);
    check("t11_nprobe", 32'(n_probes),      32'd4);
    check("t11_lat",    32'(latency),       32'd5);
    check("t11_result", 32'(result),        32'd11);
    check("t11_found",  32'(found),         32'd1);
    check("t11_err",    32'(err),           32'd0);
    @(negedge clk);
    check("t11_done_pulse", 32'(done),   32'd0);
    check("t11_hold",       32'(result), 32'd11);
    check("t11_guess_hold", 32'(guess),  32'd11);

    // ---- target 8: MSB equal, minimum latency ----
    run_search(4'd8);
    check("t8_probes", 32'(probes_packed), 32'h0008);
    check("t8_busy",   32'(busy_cycles),   32'd1);
    check("t8_lat",    32'(latency),       32'd2);
    check("t8_result", 32'(result),        32'd8);
    check("t8_found",  32'(found),         32'd1);

    // ---- target 0: all lesser, no equal seen ----
    run_search(4'd0);
    check("t0_probes", 32'(probes_packed), 32'h8421);
    check("t0_lat",    32'(latency),       32'd5);
    check("t0_result", 32'(result),        32'd0);
    check("t0_found",  32'(found),         32'd0);
    check("t0_err",    32'(err),           32'd0);

    // ---- target 15 ----
    run_search(4'd15);
    check("t15_probes", 32'(probes_packed), 32'h8CEF);
    check("t15_lat",    32'(latency),       32'd5);
    check("t15_result", 32'(result),        32'd15);
    check("t15_found",  32'(found),         32'd1);

    // ---- invalid flags on the 2nd probe: none set, then two set ----
    inj_guess = 4'd12;
    for (int m = 1; m <= 2; m++) begin
      inj_mode = m;
      run_search(4'd11);
      check($sformatf("inj%0d_probes", m), 32'(probes_packed), 32'h008C);
      check($sformatf("inj%0d_lat", m),    32'(latency),       32'd3);
      check($sformatf("inj%0d_err", m),    32'(err),           32'd1);
      check($sformatf("inj%0d_result", m), 32'(result),        32'd12);
      check($sformatf("inj%0d_found", m),  32'(found),         32'd0);
    end
    inj_mode = 0;

    // ---- start re-pulsed while busy: ignored, single done ----
    target = 4'd5;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("rs_err_cleared", 32'(err), 32'd0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("rs_done_cnt", 32'(done_cnt), 32'd1);
    check("rs_result",   32'(result),   32'd5);
    check("rs_found",    32'(found),    32'd1);

    // ---- reset during the 3rd probe ----
    target = 4'd11;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_busy = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (n_busy == 3) break;
    end
    check("mr_guess3", 32'(guess), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    check("mr_guess",  32'(guess),  32'd0);
    check("mr_busy",   32'(busy),   32'd0);
    check("mr_done",   32'(done),   32'd0);
    check("mr_result", 32'(result), 32'd0);
    check("mr_found",  32'(found),  32'd0);
    check("mr_err",    32'(err),    32'd0);
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("mr_no_done", 32'(done_cnt), 32'd0);
    rst_n = 1'b1;
    run_search(4'd6);
    check("mr_after_probes", 32'(probes_packed), 32'h0846);
    check("mr_after_lat",    32'(latency),       32'd4);
    check("mr_after_result", 32'(result),        32'd6);
    check("mr_after_found",  32'(found),         32'd1);

    // ---- sweep 0..15 with start held high ----
    @(negedge clk);
    start = 1'b1;
    for (int t = 0; t < 16; t++) begin
      target = 4'(t);
      if (t > 0) begin
        @(negedge clk);
        check($sformatf("sw%0d_restart", t), 32'(busy), 32'd1);
      end
      wait_done(seen);
      check($sformatf("sw%0d_done", t),   32'(seen),   32'd1);
      check($sformatf("sw%0d_result", t), 32'(result), 32'(t));
      check($sformatf("sw%0d_found", t),  32'(found),  (t != 0) ? 32'd1 : 32'd0);
      check($sformatf("sw%0d_err", t),    32'(err),    32'd0);
      @(negedge clk);
      check($sformatf("sw%0d_gap", t), 32'({busy, done}), 32'd0);
      if (t == 15) start = 1'b0;
    end
    @(negedge clk);
    check("sw_end_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
